// File: rtl/eeprom_rw_ctrl_pkg.sv
// rtl/eeprom_rw_ctrl_pkg.sv - shared constants for the EEPROM read/write sequencer
// Holds the FSM state encoding, the rw direction values and the default
// timing/pattern values, which the display-stage top also reuses.
package eeprom_rw_ctrl_pkg;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] WR_REQ   = 3'd1;
  localparam logic [2:0] WR_GAP_S = 3'd2;
  localparam logic [2:0] RD_REQ   = 3'd3;
  localparam logic [2:0] SHOW     = 3'd4;
  localparam logic [2:0] ERR      = 3'd5;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  localparam int unsigned CNT_W = 25;

  localparam logic [24:0] DEF_DWELL_CNT = 25'd25_000_000;
  localparam logic [17:0] DEF_WR_GAP    = 18'd250_000;
  localparam logic [7:0]  DEF_SEED      = 8'h5A;

  // Byte stored at address a: (a + seed) mod 256.
  function automatic logic [7:0] pattern(input logic [7:0] a, input logic [7:0] seed);
    return a + seed;
  endfunction

endpackage

// File: rtl/eeprom_rw_ctrl_tick_timer.sv
// rtl/eeprom_rw_ctrl_tick_timer.sv - clearable up-counter with terminal-count pulse
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : synchronous clear to 0 (wins over counting)
//   en_i       : count enable
//   term_i     : terminal value; counter runs 0..term_i then wraps to 0
//   tc_o       : high while enabled and the count equals term_i
module tick_timer #(
  parameter int unsigned W = 25
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] term_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;

  assign tc_o = en_i && (cnt_q == term_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i || tc_o) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/eeprom_rw_ctrl.sv
// rtl/eeprom_rw_ctrl.sv - writes a seeded pattern to a 256x8 I2C EEPROM, then reads it back forever
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   key_start_i     : single-cycle start pulse (honoured in IDLE and ERR only)
//   req_o/rw_o      : byte-driver request and direction (0 write, 1 read)
//   addr_o          : EEPROM word address, wr_data_o : write byte
//   done_i          : driver completion pulse, ack_err_i : NACK, rd_data_i : read byte
//   data_o          : byte shown on the display stage
//   busy_o/err_o    : activity flag, sticky NACK flag
//   mismatch_o      : sticky read-back compare failure
module eeprom_rw_ctrl
  import eeprom_rw_ctrl_pkg::*;
#(
  parameter logic [24:0] DWELL_CNT = DEF_DWELL_CNT,
  parameter logic [17:0] WR_GAP    = DEF_WR_GAP,
  parameter logic [7:0]  SEED      = DEF_SEED
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_start_i,
  output logic       req_o,
  output logic       rw_o,
  output logic [7:0] addr_o,
  output logic [7:0] wr_data_o,
  input  logic       done_i,
  input  logic       ack_err_i,
  input  logic [7:0] rd_data_i,
  output logic [7:0] data_o,
  output logic       busy_o,
  output logic       err_o,
  output logic       mismatch_o
);

  logic [2:0] state_q, state_d;
  logic       req_q, req_d;
  logic       rw_q, rw_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic [7:0] data_q, data_d;
  logic       busy_q, busy_d;
  logic       err_q, err_d;
  logic       mism_q, mism_d;

  // One counter shared by the write gap and the display dwell; it is held
  // at zero in every other state so each timed state starts from 0.
  logic             tmr_en;
  logic [CNT_W-1:0] tmr_term;
  logic             tmr_tc;

  assign tmr_en   = (state_q == WR_GAP_S) || (state_q == SHOW);
  assign tmr_term = (state_q == SHOW) ? (DWELL_CNT - 25'd1)
                                      : ({7'd0, WR_GAP} - 25'd1);

  tick_timer #(.W(CNT_W)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (!tmr_en),
    .en_i   (tmr_en),
    .term_i (tmr_term),
    .tc_o   (tmr_tc)
  );

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    addr_d    = addr_q;
    data_d    = data_q;
    err_d     = err_q;
    mism_d    = mism_q;
    rw_d      = rw_q;
    wr_data_d = wr_data_q;

    case (state_q)
      IDLE: begin
        if (key_start_i) begin
          addr_d  = 8'd0;
          state_d = WR_REQ;
        end
      end
      WR_REQ: begin
        // req is raised one cycle after entry; done only counts while req=1.
        if (req_q && done_i) begin
          req_d = 1'b0;
          if (ack_err_i) begin
            err_d   = 1'b1;
            state_d = ERR;
          end else begin
            state_d = WR_GAP_S;
          end
        end else begin
          req_d = 1'b1;
        end
      end
      WR_GAP_S: begin
        if (tmr_tc) begin
          if (addr_q == 8'hFF) begin
            addr_d  = 8'd0;
            state_d = RD_REQ;
          end else begin
            addr_d  = addr_q + 8'd1;
            state_d = WR_REQ;
          end
        end
      end
      RD_REQ: begin
        if (req_q && done_i) begin
          req_d = 1'b0;
          if (ack_err_i) begin
            err_d   = 1'b1;
            state_d = ERR;
          end else begin
            data_d = rd_data_i;
            if (rd_data_i != pattern(addr_q, SEED)) begin
              mism_d = 1'b1;
            end
            state_d = SHOW;
          end
        end else begin
          req_d = 1'b1;
        end
      end
      SHOW: begin
        if (tmr_tc) begin
          addr_d  = addr_q + 8'd1;
          state_d = RD_REQ;
        end
      end
      ERR: begin
        if (key_start_i) begin
          err_d   = 1'b0;
          mism_d  = 1'b0;
          addr_d  = 8'd0;
          state_d = WR_REQ;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase

    // Direction and write byte are loaded on entry to a request state so they
    // are already stable when req rises and stay put until it falls.
    if (state_d == WR_REQ && state_q != WR_REQ) begin
      rw_d      = RW_WRITE;
      wr_data_d = pattern(addr_d, SEED);
    end else if (state_d == RD_REQ && state_q != RD_REQ) begin
      rw_d = RW_READ;
    end

    busy_d = (state_d != IDLE) && (state_d != ERR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      rw_q      <= RW_WRITE;
      addr_q    <= 8'd0;
      wr_data_q <= 8'd0;
      data_q    <= 8'd0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      mism_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      mism_q    <= mism_d;
    end
  end

  assign req_o      = req_q;
  assign rw_o       = rw_q;
  assign addr_o     = addr_q;
  assign wr_data_o  = wr_data_q;
  assign data_o     = data_q;
  assign busy_o     = busy_q;
  assign err_o      = err_q;
  assign mismatch_o = mism_q;

endmodule

// File: tb/tb_eeprom_rw_ctrl.sv
// tb/tb_eeprom_rw_ctrl.sv - directed self-checking bench for eeprom_rw_ctrl
module tb_eeprom_rw_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_start = 1'b0;
  logic       done = 1'b0;
  logic       ack_err = 1'b0;
  logic [7:0] rd_data = 8'h00;
  logic       req_o, rw_o, busy_o, err_o, mismatch_o;
  logic [7:0] addr_o, wr_data_o, data_o;

  int checks = 0;
  int errors = 0;
  bit timed_out = 1'b0;

  // EEPROM / byte-driver model
  logic [7:0] mem [256];
  int nack_addr = -1;
  int bad_addr  = -1;
  int rcnt      = 0;

  always #5 clk = ~clk;

  eeprom_rw_ctrl #(
    .DWELL_CNT (25'd10),
    .WR_GAP    (18'd4),
    .SEED      (8'h5A)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_start_i (key_start),
    .req_o       (req_o),
    .rw_o        (rw_o),
    .addr_o      (addr_o),
    .wr_data_o   (wr_data_o),
    .done_i      (done),
    .ack_err_i   (ack_err),
    .rd_data_i   (rd_data),
    .data_o      (data_o),
    .busy_o      (busy_o),
    .err_o       (err_o),
    .mismatch_o  (mismatch_o)
  );

  // Driver returns done on the third cycle req has been high.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    forever begin
      @(negedge clk);
      done    = 1'b0;
      ack_err = 1'b0;
      if (!rst_n || req_o !== 1'b1) begin
        rcnt = 0;
      end else begin
        rcnt++;
        if (rcnt == 3) begin
          done = 1'b1;
          if (rw_o == 1'b0) begin
            if (int'(addr_o) == nack_addr) ack_err = 1'b1;
            else mem[addr_o] = wr_data_o;
          end else begin
            rd_data = (int'(addr_o) == bad_addr) ? 8'h00 : mem[addr_o];
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_req(input logic lvl, input string tag);
    int k;
    k = 0;
    if (timed_out) return;
    while (req_o !== lvl && k < 300) begin
      step();
      k++;
    end
    if (req_o !== lvl) begin
      timed_out = 1'b1;
      chk(tag, {31'd0, req_o}, {31'd0, lvl});
    end
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    if (timed_out) return;
    while (done !== 1'b1 && k < 300) begin
      step();
      k++;
    end
    if (done !== 1'b1) begin
      timed_out = 1'b1;
      chk(tag, {31'd0, done}, 32'd1);
    end
  endtask

  task automatic pulse_key();
    key_start = 1'b1;
    step();
    key_start = 1'b0;
  endtask

  initial begin
    #600_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int bad;
    logic any_req;

    // 1. reset, then idle with no key
    step(3);
    chk("rst_req", req_o, 0);
    chk("rst_data", data_o, 0);
    rst_n = 1'b1;
    any_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      any_req |= req_o;
    end
    chk("idle_no_req", any_req, 0);
    chk("idle_busy", busy_o, 0);
    chk("idle_outs", {rw_o, addr_o, wr_data_o, data_o, err_o, mismatch_o}, 0);

    // 2. start, first write, gap, second write
    pulse_key();
    chk("start_busy", busy_o, 1);
    chk("start_req_low", req_o, 0);
    step();
    chk("wr0_req", req_o, 1);
    chk("wr0_rw", rw_o, 0);
    chk("wr0_addr", addr_o, 8'h00);
    chk("wr0_data", wr_data_o, 8'h5A);
    wait_done("wr0_done_to");
    step();
    chk("wr0_req_fall", req_o, 0);
    k = 0;
    while (req_o == 1'b0 && k < 50) begin
      step();
      k++;
    end
    chk("wr_gap_cycles", k, 5);
    chk("wr1_addr", addr_o, 8'h01);
    chk("wr1_data", wr_data_o, 8'h5B);

    // 3. remaining writes; a key pulse mid-gap must be ignored
    bad = 0;
    for (int a = 1; a < 256; a++) begin
      wait_req(1'b1, "wr_req_to");
      if (addr_o !== 8'(a) || wr_data_o !== 8'(a + 8'h5A) || rw_o !== 1'b0) bad++;
      if (a == 255) chk("wr_ff_data", wr_data_o, 8'h59);
      wait_req(1'b0, "wr_fall_to");
      if (a == 16) begin
        step();
        pulse_key();
      end
    end
    chk("wr_seq_bad", bad, 0);

    wait_req(1'b1, "rd0_to");
    chk("rd0_rw", rw_o, 1);
    chk("rd0_addr", addr_o, 8'h00);
    wait_done("rd0_done_to");
    step();
    chk("rd0_req_fall", req_o, 0);
    chk("rd0_data", data_o, 8'h5A);
    k = 0;
    while (req_o == 1'b0 && k < 50) begin
      step();
      k++;
    end
    chk("show_cycles", k, 11);
    chk("show_hold", data_o, 8'h5A);
    chk("rd1_addr", addr_o, 8'h01);
    chk("rd1_rw", rw_o, 1);

    // 4. read through FF and wrap
    bad = 0;
    for (int a = 1; a < 256; a++) begin
      wait_req(1'b1, "rd_req_to");
      if (addr_o !== 8'(a) || rw_o !== 1'b1 || mismatch_o !== 1'b0 || busy_o !== 1'b1) bad++;
      wait_req(1'b0, "rd_fall_to");
      if (data_o !== 8'(a + 8'h5A) || busy_o !== 1'b1) bad++;
    end
    chk("rd_seq_bad", bad, 0);
    wait_req(1'b1, "rd_wrap_to");
    chk("rd_wrap_addr", addr_o, 8'h00);
    chk("rd_wrap_mismatch", mismatch_o, 0);
    chk("rd_wrap_busy", busy_o, 1);

    // 5. NACK on write to addr 03
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    nack_addr = 3;
    pulse_key();
    for (int a = 0; a < 3; a++) begin
      wait_req(1'b1, "nk_req_to");
      wait_req(1'b0, "nk_fall_to");
    end
    wait_req(1'b1, "nk3_to");
    chk("nk3_addr", addr_o, 8'h03);
    wait_done("nk3_done_to");
    step();
    chk("nk_err", err_o, 1);
    chk("nk_busy", busy_o, 0);
    chk("nk_req", req_o, 0);
    any_req = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      any_req |= req_o;
    end
    chk("nk_no_req", any_req, 0);
    nack_addr = -1;
    pulse_key();
    chk("nk_clr_err", err_o, 0);
    chk("nk_restart_busy", busy_o, 1);
    step();
    chk("nk_restart_req", req_o, 1);
    chk("nk_restart_addr", addr_o, 8'h00);
    chk("nk_restart_data", wr_data_o, 8'h5A);

    // 6. bad read byte at addr 07, then reset during a request
    bad_addr = 7;
    for (int a = 0; a < 256; a++) begin
      wait_req(1'b1, "w6_req_to");
      wait_req(1'b0, "w6_fall_to");
    end
    for (int a = 0; a < 7; a++) begin
      wait_req(1'b1, "r6_req_to");
      wait_req(1'b0, "r6_fall_to");
    end
    chk("r6_pre_mismatch", mismatch_o, 0);
    wait_req(1'b1, "r7_to");
    chk("r7_addr", addr_o, 8'h07);
    wait_done("r7_done_to");
    step();
    chk("r7_data", data_o, 8'h00);
    chk("r7_mismatch", mismatch_o, 1);
    wait_req(1'b1, "r8_to");
    chk("r8_addr", addr_o, 8'h08);
    chk("r8_mismatch", mismatch_o, 1);
    wait_req(1'b0, "r8_fall_to");
    wait_req(1'b1, "r9_to");
    chk("r9_addr", addr_o, 8'h09);
    chk("r9_prev_data", data_o, 8'h62);
    chk("r9_mismatch", mismatch_o, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_req", req_o, 0);
    chk("arst_data", data_o, 8'h00);
    chk("arst_mismatch", mismatch_o, 0);
    chk("arst_busy", busy_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
